// File: rtl/run_dump_pkg.sv
// run_dump_pkg: shared state encoding and sizing helpers for the run/dump controller
package run_dump_pkg;
  typedef enum logic [2:0] {IDLE, PRE_DUMP, RESET_HOLD, RUN, DRAIN, POST_DUMP, DONE} state_t;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int BYTES_PER_WORD = DATA_WIDTH_DEF / 8;
  function automatic int step_bytes(input int dw);
    return dw / 8;
  endfunction
  // index ports stay at least one bit wide even for an empty window
  function automatic int idx_width(input int n);
    return n < 1 ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/dump_sequencer.sv
// dump_sequencer: walks the dump window word by word over a req/ack read handshake
module dump_sequencer
  import run_dump_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] DUMP_BASE = 'd8192,
  parameter int DUMP_WORDS = 11,
  localparam int IW = idx_width(DUMP_WORDS)
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_go,
  input  logic                  i_phase,
  input  logic                  i_ack,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_req,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_word_valid,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic [IW-1:0]         o_index,
  output logic                  o_phase,
  output logic                  o_finished
);
  logic                  r_req, r_valid, r_phase, r_fin;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [IW-1:0]         r_idx, r_out_idx;
  logic [DATA_WIDTH-1:0] r_word;
  logic                  w_take, w_last;
  assign w_take = r_req && i_ack;
  assign w_last = r_idx == IW'(DUMP_WORDS - 1);
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_req     <= 1'b0;
      r_addr    <= DUMP_BASE;
      r_idx     <= '0;
      r_out_idx <= '0;
      r_word    <= '0;
      r_valid   <= 1'b0;
      r_phase   <= 1'b0;
      r_fin     <= 1'b0;
    end else begin
      r_valid <= w_take;
      r_fin   <= i_go ? (DUMP_WORDS == 0) : (w_take && w_last);
      if (i_go) begin
        r_req   <= DUMP_WORDS != 0;
        r_addr  <= DUMP_BASE;
        r_idx   <= '0;
        r_phase <= i_phase;
      end else if (w_take) begin
        r_word    <= i_data;
        r_out_idx <= r_idx;
        r_idx     <= r_idx + 1'b1;
        r_addr    <= r_addr + ADDR_WIDTH'(step_bytes(DATA_WIDTH));
        r_req     <= !w_last;
      end
    end
  end
  assign o_req        = r_req;
  assign o_addr       = r_addr;
  assign o_word_valid = r_valid;
  assign o_word       = r_word;
  assign o_index      = r_out_idx;
  assign o_phase      = r_phase;
  assign o_finished   = r_fin;
endmodule

// File: rtl/run_dump_controller.sv
// run_dump_controller: holds/releases processor reset, times the run, and dumps memory before/after
module run_dump_controller
  import run_dump_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = 32,
  parameter int RESET_CYCLES = 1,
  parameter logic [ADDR_WIDTH-1:0] DUMP_BASE = 'd8192,
  parameter int DUMP_WORDS = 11,
  parameter bit DUMP_INITIAL = 1'b1,
  parameter int DRAIN_CYCLES = 4,
  parameter bit HALT_EN = 1'b1,
  parameter logic [DATA_WIDTH-1:0] HALT_INSTR = '0,
  parameter int unsigned TIMEOUT = 100000,
  localparam int IW = idx_width(DUMP_WORDS)
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_instr,
  input  logic                  i_instr_valid,
  output logic                  o_proc_reset,
  output logic                  o_dump_req,
  output logic [ADDR_WIDTH-1:0] o_dump_addr,
  input  logic                  i_dump_ack,
  input  logic [DATA_WIDTH-1:0] i_dump_data,
  output logic                  o_dump_word_valid,
  output logic [DATA_WIDTH-1:0] o_dump_word,
  output logic [IW-1:0]         o_dump_index,
  output logic                  o_dump_phase,
  output logic [31:0]           o_cycle_count,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_timed_out
);
  localparam int RH = RESET_CYCLES < 1 ? 1 : RESET_CYCLES;
  localparam state_t FIRST = (DUMP_WORDS > 0 && DUMP_INITIAL) ? PRE_DUMP : RESET_HOLD;
  localparam state_t POST = DUMP_WORDS > 0 ? POST_DUMP : DONE;
  localparam state_t END_RUN = DRAIN_CYCLES > 0 ? DRAIN : POST;
  state_t      r_state, w_next;
  logic [31:0] r_cnt, r_cycles;
  logic        r_timed_out;
  logic        w_idle, w_halt, w_timeout, w_go, w_fin;
  assign w_idle    = r_state == IDLE || r_state == DONE;
  assign w_halt    = !i_instr_valid || (HALT_EN && i_instr == HALT_INSTR);
  assign w_timeout = TIMEOUT != 0 && r_cycles == 32'(TIMEOUT - 1);
  assign w_go      = w_next != r_state && (w_next == PRE_DUMP || w_next == POST_DUMP);
  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: w_next = i_start ? FIRST : r_state;
      PRE_DUMP:   w_next = w_fin ? RESET_HOLD : PRE_DUMP;
      RESET_HOLD: w_next = r_cnt == 32'(RH - 1) ? RUN : RESET_HOLD;
      RUN:        w_next = (w_halt || w_timeout) ? END_RUN : RUN;
      DRAIN:      w_next = r_cnt == 32'(DRAIN_CYCLES - 1) ? POST : DRAIN;
      POST_DUMP:  w_next = w_fin ? DONE : POST_DUMP;
      default:    w_next = IDLE;
    endcase
  end
  always_comb begin
    o_proc_reset = !(r_state == RUN || r_state == DRAIN);
    o_busy       = !w_idle;
    o_done       = r_state == DONE;
  end
  // r_cnt restarts on every state change so hold and drain share it
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cnt       <= '0;
      r_cycles    <= '0;
      r_timed_out <= 1'b0;
    end else begin
      r_cnt <= w_next != r_state ? '0 : r_cnt + 1;
      if (w_idle && i_start) begin
        r_cycles    <= '0;
        r_timed_out <= 1'b0;
      end else if (r_state == RUN) begin
        r_cycles    <= r_cycles + 32'(r_cycles != '1);
        r_timed_out <= w_timeout && !w_halt;
      end
    end
  end
  assign o_cycle_count = r_cycles;
  assign o_timed_out   = r_timed_out;
  dump_sequencer #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DUMP_BASE (DUMP_BASE),
    .DUMP_WORDS(DUMP_WORDS)
  ) u_seq (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_go        (w_go),
    .i_phase     (w_next == POST_DUMP),
    .i_ack       (i_dump_ack),
    .i_data      (i_dump_data),
    .o_req       (o_dump_req),
    .o_addr      (o_dump_addr),
    .o_word_valid(o_dump_word_valid),
    .o_word      (o_dump_word),
    .o_index     (o_dump_index),
    .o_phase     (o_dump_phase),
    .o_finished  (w_fin)
  );
endmodule
